// File: rtl/alu_pkg.sv
// Shared definitions for the KGPRISC execute-stage ALU: width, opcodes, flag bit positions.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_COMP  = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SHLL  = 4'b0100;
    localparam logic [3:0] ALU_SHRL  = 4'b0101;
    localparam logic [3:0] ALU_SHLLV = 4'b0110;
    localparam logic [3:0] ALU_SHRLV = 4'b0111;
    localparam logic [3:0] ALU_SHRA  = 4'b1000;
    localparam logic [3:0] ALU_SHRAV = 4'b1001;
    localparam logic [3:0] ALU_SUB   = 4'b1010;
    localparam logic [3:0] ALU_OR    = 4'b1011;
    localparam logic [3:0] ALU_ROL   = 4'b1100;
    localparam logic [3:0] ALU_ROR   = 4'b1101;

    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 0;

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter: logical/arithmetic shifts and rotates,
// plus the last bit moved across the word boundary (zero for a zero amount).
module alu_shifter
    import alu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [4:0]  amount,
    input  logic        dir_right,
    input  logic        arith,
    input  logic        rotate,
    output logic [31:0] result,
    output logic        carry
);

    logic [5:0] inv_amt;
    logic [4:0] carry_idx;

    // Select shift flavour; the carry bit is data[32-n] going left, data[n-1] going right,
    // which is also the bit a rotate wraps last.
    always_comb begin
        inv_amt   = 6'd32 - {1'b0, amount};
        carry_idx = 5'd0;
        result    = data;
        carry     = 1'b0;
        if (dir_right) begin
            carry_idx = amount - 5'd1;
            if (rotate) begin
                result = (data >> amount) | (data << inv_amt);
            end else if (arith) begin
                result = $unsigned($signed(data) >>> amount);
            end else begin
                result = data >> amount;
            end
        end else begin
            carry_idx = inv_amt[4:0];
            if (rotate) begin
                result = (data << amount) | (data >> inv_amt);
            end else begin
                result = data << amount;
            end
        end
        if (amount != 5'd0) begin
            carry = data[carry_idx];
        end
    end

endmodule

// File: rtl/alu_core.sv
// 32-bit execute-stage ALU with registered result and {carry, negative, zero} flags.
// Optional rotate opcodes (ROL/ROR on 1100/1101) are built only when ALU_ROTATE_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       shamt,
    input  logic [3:0]       control,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flag
);

    logic [31:0] out_d, out_q;
    logic [2:0]  flag_d, flag_q;

    logic [4:0]  sh_amt;
    logic        sh_right, sh_arith, sh_rot;
    logic [31:0] sh_result;
    logic        sh_carry;

    logic [31:0] add_a, add_b;
    logic        add_cin;
    logic [32:0] add_sum;
    logic        carry;

    alu_shifter u_shifter (
        .data      (in1),
        .amount    (sh_amt),
        .dir_right (sh_right),
        .arith     (sh_arith),
        .rotate    (sh_rot),
        .result    (sh_result),
        .carry     (sh_carry)
    );

    // Shifter controls: variable forms take the amount from in2[4:0].
    always_comb begin
        sh_amt   = shamt;
        sh_right = 1'b0;
        sh_arith = 1'b0;
        sh_rot   = 1'b0;
        if (control == ALU_SHLLV || control == ALU_SHRLV || control == ALU_SHRAV) begin
            sh_amt = in2[4:0];
        end
        if (control == ALU_SHRL || control == ALU_SHRLV ||
            control == ALU_SHRA || control == ALU_SHRAV) begin
            sh_right = 1'b1;
        end
        if (control == ALU_SHRA || control == ALU_SHRAV) begin
            sh_arith = 1'b1;
        end
`ifdef ALU_ROTATE_EN
        if (control == ALU_ROL || control == ALU_ROR) begin
            sh_rot = 1'b1;
        end
        if (control == ALU_ROR) begin
            sh_right = 1'b1;
        end
`endif
    end

    // One shared 33-bit adder serves ADD, COMP (0 + ~in2 + 1) and SUB (in1 + ~in2 + 1).
    always_comb begin
        add_a   = in1;
        add_b   = in2;
        add_cin = 1'b0;
        if (control == ALU_COMP) begin
            add_a   = 32'd0;
            add_b   = ~in2;
            add_cin = 1'b1;
        end else if (control == ALU_SUB) begin
            add_b   = ~in2;
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    end

    // Result/carry mux and flag derivation; unused opcodes pass in1 with carry clear.
    always_comb begin
        out_d = in1;
        carry = 1'b0;
        case (control)
            ALU_ADD, ALU_COMP, ALU_SUB: begin
                out_d = add_sum[31:0];
                carry = add_sum[32];
            end
            ALU_AND: out_d = in1 & in2;
            ALU_XOR: out_d = in1 ^ in2;
            ALU_OR:  out_d = in1 | in2;
            ALU_SHLL, ALU_SHRL, ALU_SHLLV, ALU_SHRLV, ALU_SHRA, ALU_SHRAV: begin
                out_d = sh_result;
                carry = sh_carry;
            end
`ifdef ALU_ROTATE_EN
            ALU_ROL, ALU_ROR: begin
                out_d = sh_result;
                carry = sh_carry;
            end
`endif
            default: begin
                out_d = in1;
                carry = 1'b0;
            end
        endcase
        flag_d             = 3'b000;
        flag_d[FLAG_CARRY] = carry;
        flag_d[FLAG_NEG]   = out_d[31];
        flag_d[FLAG_ZERO]  = (out_d == 32'd0);
    end

    // Output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 32'd0;
            flag_q <= 3'b000;
        end else begin
            out_q  <= out_d;
            flag_q <= flag_d;
        end
    end

    assign out  = out_q;
    assign flag = flag_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed testbench for alu_core: reset behaviour, each opcode, carry/zero/negative corners.
// Rotate vectors are exercised when ALU_ROTATE_EN is defined; otherwise 1100 is checked as reserved.
module tb_alu_core;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1, in2;
    logic [4:0]  shamt;
    logic [3:0]  control;
    logic [31:0] out;
    logic [2:0]  flag;

    int checks = 0;
    int errors = 0;

    alu_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in1     (in1),
        .in2     (in2),
        .shamt   (shamt),
        .control (control),
        .out     (out),
        .flag    (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_out, input logic [2:0] exp_flag);
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL %s out: got %h expected %h", tag, out, exp_out);
        end
        checks++;
        assert (flag === exp_flag) else begin
            errors++;
            $error("FAIL %s flag: got %b expected %b", tag, flag, exp_flag);
        end
    endtask

    // Drive one op, let it be captured on the next rising edge, sample 1 time unit later.
    task automatic step(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
        control = ctl;
        in1     = a;
        in2     = b;
        shamt   = sh;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        in1     = 32'd0;
        in2     = 32'd0;
        shamt   = 5'd0;
        control = ALU_ADD;
        #12;
        check("reset_state", 32'd0, 3'b000);
        rst_n = 1'b1;

        step(ALU_ADD, 32'd0, 32'd5, 5'd0);
        check("add_0_5", 32'd5, 3'b000);

        // Asynchronous reset mid-operation, then recovery on the following edge.
        control = ALU_ADD;
        in1     = 32'd7;
        in2     = 32'd9;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'd0, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset_add", 32'd16, 3'b000);

        step(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("add_wrap", 32'd0, 3'b101);

        for (int i = 0; i < 4; i++) begin
            step(ALU_COMP, 32'd105, 32'd106, 5'd0);
            check("comp_106", 32'hFFFF_FF96, 3'b010);
        end
        step(ALU_COMP, 32'd105, 32'd0, 5'd0);
        check("comp_zero", 32'd0, 3'b101);

        step(ALU_SUB, 32'd105, 32'd106, 5'd0);
        check("sub_borrow", 32'hFFFF_FFFF, 3'b010);
        step(ALU_SUB, 32'd106, 32'd105, 5'd0);
        check("sub_noborrow", 32'd1, 3'b100);

        step(ALU_SHRA, 32'h8000_0000, 32'd0, 5'd4);
        check("shra_4", 32'hF800_0000, 3'b010);
        step(ALU_SHRLV, 32'h0000_0003, 32'h0000_0021, 5'd7);
        check("shrlv_amt1", 32'd1, 3'b100);
        step(ALU_SHLL, 32'h1234_5678, 32'd0, 5'd0);
        check("shll_zero", 32'h1234_5678, 3'b000);
        step(ALU_SHLL, 32'h8000_0001, 32'd0, 5'd1);
        check("shll_carry", 32'h0000_0002, 3'b100);
        step(ALU_SHRL, 32'h8000_0000, 32'd0, 5'd31);
        check("shrl_31", 32'd1, 3'b000);
        step(ALU_SHLLV, 32'd1, 32'hFFFF_FFFF, 5'd0);
        check("shllv_31", 32'h8000_0000, 3'b010);
        step(ALU_SHRAV, 32'h8000_0001, 32'd1, 5'd9);
        check("shrav_1", 32'hC000_0000, 3'b110);

        step(ALU_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd0);
        check("and_zero", 32'd0, 3'b001);
        step(ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0);
        check("xor", 32'hF00F_F00F, 3'b010);
        step(ALU_OR, 32'h0000_0001, 32'h8000_0000, 5'd0);
        check("or", 32'h8000_0001, 3'b010);

        step(4'b1110, 32'd0, 32'h1234_5678, 5'd3);
        check("reserved_1110", 32'd0, 3'b001);
        step(4'b1111, 32'h1234_5678, 32'hFFFF_FFFF, 5'd3);
        check("reserved_1111", 32'h1234_5678, 3'b000);

`ifdef ALU_ROTATE_EN
        step(ALU_ROR, 32'd1, 32'd0, 5'd1);
        check("ror_1", 32'h8000_0000, 3'b110);
        step(ALU_ROL, 32'h8000_0000, 32'd0, 5'd1);
        check("rol_1", 32'd1, 3'b100);
        step(ALU_ROL, 32'h8000_0000, 32'd0, 5'd0);
        check("rol_0", 32'h8000_0000, 3'b010);
`else
        step(ALU_ROL, 32'd1, 32'd0, 5'd1);
        check("reserved_1100", 32'd1, 3'b000);
        step(ALU_ROR, 32'd1, 32'd0, 5'd1);
        check("reserved_1101", 32'd1, 3'b000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
